dispatch_queue_arbiter: RTL and testbench

- Sits between the parallel format decoders (XO, D, X, ... formats) and the functional units.
- Each cycle it accepts at most one decoded instruction, picking the lowest-index decoder with enable high, and buffers it in a small in-order FIFO.
- It issues the FIFO head to the bus of the target functional unit when that unit signals ready.
- It drives the shared stall back to the decoders and flags conflicts, overflows and bad unit codes.

---
 rtl/dispatch_queue_arbiter_pkg.sv | 46 ++++
 rtl/dispatch_queue_arbiter_sync_fifo.sv | 62 ++++++
 rtl/dispatch_queue_arbiter.sv | 150 +++++++++++++++
 tb/tb_dispatch_queue_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_arbiter_pkg.sv
// Shared decode/issue definitions used by the format decoders, this queue and the functional units.
// Field offsets count from the payload MSB: reg1 is the most significant field, fuCode the least.
package dispatch_queue_arbiter_pkg;

    localparam int NUM_UNITS     = 5;
    localparam int REG_WIDTH     = 5;
    localparam int XOP_WIDTH     = 9;
    localparam int FU_WIDTH      = 3;
    localparam int PAYLOAD_WIDTH = 29;

    localparam int OFF_REG1 = 0;
    localparam int OFF_REG2 = 5;
    localparam int OFF_REG3 = 10;
    localparam int OFF_XOP  = 15;
    localparam int OFF_BIT1 = 24;
    localparam int OFF_BIT2 = 25;
    localparam int OFF_FU   = 26;

    typedef enum logic [FU_WIDTH-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_LDST   = 3'd2,
        FU_BRANCH = 3'd3,
        FU_TRAP   = 3'd4
    } fu_code_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0] reg1;
        logic [REG_WIDTH-1:0] reg2;
        logic [REG_WIDTH-1:0] reg3;
        logic [XOP_WIDTH-1:0] xop;
        logic                 bit1;
        logic                 bit2;
        logic [FU_WIDTH-1:0]  fu_code;
    } dec_payload_t;

    // Converts an MSB-relative field offset into the LSB index of a little-endian vector.
    function automatic int field_lsb(input int off, input int width);
        return PAYLOAD_WIDTH - off - width;
    endfunction

    function automatic logic [FU_WIDTH-1:0] fu_code_of(input logic [PAYLOAD_WIDTH-1:0] p);
        return p[field_lsb(OFF_FU, FU_WIDTH) +: FU_WIDTH];
    endfunction

endpackage

// File: rtl/dispatch_queue_arbiter_sync_fifo.sv
// In-order FIFO with combinational head read; push and pop may coincide even when full.
// Caller must not push when full without a simultaneous pop, nor pop when empty.
module dispatch_queue_arbiter_sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_dat_i,
    output logic [WIDTH-1:0]           rd_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/dispatch_queue_arbiter.sv
// Picks the lowest enabled decoder, queues it in order and issues the head to its unit when ready.
// Two-cycle minimum latency; stall_o rises at fifoDepth-1 entries, arrivals into a full queue are dropped.
module dispatch_queue_arbiter
    import dispatch_queue_arbiter_pkg::*;
#(
    parameter int numDecoders  = 4,
    parameter int regWidth     = REG_WIDTH,
    parameter int xOpCodeWidth = XOP_WIDTH,
    parameter int payloadWidth = PAYLOAD_WIDTH,
    parameter int fifoDepth    = 4,
    parameter int numUnits     = NUM_UNITS
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [numDecoders-1:0]              decEnable_i,
    input  logic [numDecoders*payloadWidth-1:0] decPayload_i,
    input  logic [numUnits-1:0]                 fuReady_i,
    output logic                                stall_o,
    output logic                                dispatchValid_o,
    output logic [payloadWidth-1:0]             dispatchPayload_o,
    output logic [2:0]                          dispatchUnit_o,
    output logic                                conflict_o,
    output logic                                overflow_o,
    output logic                                badUnit_o,
    output logic [$clog2(fifoDepth):0]          occupancy_o
);

    localparam int CW = $clog2(fifoDepth) + 1;

    if (payloadWidth != 3*regWidth + xOpCodeWidth + 2 + FU_WIDTH) begin : g_bad_width
        $error("payloadWidth does not match the field layout");
    end
    if ((fifoDepth < 2) || ((fifoDepth & (fifoDepth - 1)) != 0)) begin : g_bad_depth
        $error("fifoDepth must be a power of 2 and at least 2");
    end
    if (numUnits > 8) begin : g_bad_units
        $error("numUnits must fit the 3-bit unit code");
    end

    logic                    any_en;
    logic                    conflict_det;
    logic [payloadWidth-1:0] sel_dat;
    logic [payloadWidth-1:0] head_dat;
    logic [FU_WIDTH-1:0]     head_unit;
    logic [7:0]              rdy_ext;
    logic                    unit_ok;
    logic                    unit_rdy;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    discard;
    logic                    overflow_det;

    logic                    stall_q, stall_d;
    logic                    valid_q, valid_d;
    logic [payloadWidth-1:0] payload_q, payload_d;
    logic [2:0]              unit_q, unit_d;
    logic                    conflict_q, conflict_d;
    logic                    overflow_q, overflow_d;
    logic                    bad_unit_q, bad_unit_d;

    always_comb begin
        any_en       = |decEnable_i;
        conflict_det = ($countones(decEnable_i) > 1);
        sel_dat      = '0;
        // Walk downwards so the lowest enabled slot is the last to win.
        for (int i = numDecoders - 1; i >= 0; i--) begin
            if (decEnable_i[i]) begin
                sel_dat = decPayload_i[i*payloadWidth +: payloadWidth];
            end
        end
    end

    always_comb begin
        head_unit    = fu_code_of(head_dat);
        rdy_ext      = 8'(fuReady_i);
        unit_ok      = (int'(head_unit) < numUnits);
        unit_rdy     = unit_ok && rdy_ext[head_unit];
        // Bad unit codes retire immediately so they cannot wedge the queue.
        pop          = !fifo_empty && (!unit_ok || unit_rdy);
        issue        = pop && unit_ok;
        discard      = pop && !unit_ok;
        push         = any_en && (!fifo_full || pop);
        overflow_det = any_en && fifo_full && !pop;
        count_next   = count + CW'(push) - CW'(pop);
    end

    dispatch_queue_arbiter_sync_fifo #(
        .WIDTH (payloadWidth),
        .DEPTH (fifoDepth)
    ) u_sync_fifo (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_dat_i (sel_dat),
        .rd_dat_o (head_dat),
        .count_o  (count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        stall_d    = (count_next >= CW'(fifoDepth - 1));
        valid_d    = issue;
        payload_d  = payload_q;
        unit_d     = unit_q;
        if (issue) begin
            payload_d = head_dat;
            unit_d    = head_unit;
        end
        conflict_d = conflict_det;
        overflow_d = overflow_det;
        bad_unit_d = discard;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q    <= 1'b0;
            valid_q    <= 1'b0;
            payload_q  <= '0;
            unit_q     <= '0;
            conflict_q <= 1'b0;
            overflow_q <= 1'b0;
            bad_unit_q <= 1'b0;
        end else begin
            stall_q    <= stall_d;
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            unit_q     <= unit_d;
            conflict_q <= conflict_d;
            overflow_q <= overflow_d;
            bad_unit_q <= bad_unit_d;
        end
    end

    assign stall_o           = stall_q;
    assign dispatchValid_o   = valid_q;
    assign dispatchPayload_o = payload_q;
    assign dispatchUnit_o    = unit_q;
    assign conflict_o        = conflict_q;
    assign overflow_o        = overflow_q;
    assign badUnit_o         = bad_unit_q;
    assign occupancy_o       = count;

endmodule

// File: tb/tb_dispatch_queue_arbiter.sv
module tb_dispatch_queue_arbiter;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic [3:0]    decEnable_i;
    logic [115:0]  decPayload_i;
    logic [4:0]    fuReady_i;
    logic          stall_o;
    logic          dispatchValid_o;
    logic [28:0]   dispatchPayload_o;
    logic [2:0]    dispatchUnit_o;
    logic          conflict_o;
    logic          overflow_o;
    logic          badUnit_o;
    logic [2:0]    occupancy_o;

    dispatch_queue_arbiter dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .decEnable_i       (decEnable_i),
        .decPayload_i      (decPayload_i),
        .fuReady_i         (fuReady_i),
        .stall_o           (stall_o),
        .dispatchValid_o   (dispatchValid_o),
        .dispatchPayload_o (dispatchPayload_o),
        .dispatchUnit_o    (dispatchUnit_o),
        .conflict_o        (conflict_o),
        .overflow_o        (overflow_o),
        .badUnit_o         (badUnit_o),
        .occupancy_o       (occupancy_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int failures = 0;

    logic [28:0] slot [4];
    logic [28:0] mq [$];
    logic        exp_valid, exp_conflict, exp_overflow, exp_bad, exp_stall;
    logic [28:0] exp_payload;
    logic [2:0]  exp_unit;
    int          exp_occ;

    function automatic logic [28:0] mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                                       input logic [8:0] x, input logic b1, input logic b2,
                                       input logic [2:0] fu);
        return {r1, r2, r3, x, b1, b2, fu};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("valid",     32'(dispatchValid_o),   32'(exp_valid));
        chk("payload",   32'(dispatchPayload_o), 32'(exp_payload));
        chk("unit",      32'(dispatchUnit_o),    32'(exp_unit));
        chk("conflict",  32'(conflict_o),        32'(exp_conflict));
        chk("overflow",  32'(overflow_o),        32'(exp_overflow));
        chk("bad_unit",  32'(badUnit_o),         32'(exp_bad));
        chk("stall",     32'(stall_o),           32'(exp_stall));
        chk("occupancy", 32'(occupancy_o),       32'(exp_occ));
    endtask

    task automatic model_clear();
        mq.delete();
        exp_valid = 0; exp_conflict = 0; exp_overflow = 0; exp_bad = 0; exp_stall = 0;
        exp_payload = '0; exp_unit = '0; exp_occ = 0;
    endtask

    // Queue-level reference: what one rising edge does given the current inputs.
    task automatic model_edge();
        int          cnt = mq.size();
        int          nen = $countones(decEnable_i);
        int          sel = -1;
        int          u = 0;
        bit          iss = 0;
        bit          disc = 0;
        bit          pop;
        logic [28:0] h = '0;
        if (cnt > 0) begin
            h = mq[0];
            u = int'(h[2:0]);
            if (u >= 5) disc = 1;
            else if (fuReady_i[u]) iss = 1;
        end
        pop = iss || disc;
        for (int i = 3; i >= 0; i--) if (decEnable_i[i]) sel = i;
        exp_overflow = 0;
        if (pop) void'(mq.pop_front());
        if (sel >= 0) begin
            if (cnt < 4 || pop) mq.push_back(slot[sel]);
            else exp_overflow = 1;
        end
        exp_conflict = (nen > 1);
        exp_valid    = iss;
        if (iss) begin
            exp_payload = h;
            exp_unit    = h[2:0];
        end
        exp_bad   = disc;
        exp_occ   = mq.size();
        exp_stall = (mq.size() >= 3);
    endtask

    task automatic cycle(input logic [3:0] en, input logic [4:0] rdy);
        decEnable_i = en;
        fuReady_i   = rdy;
        for (int i = 0; i < 4; i++) decPayload_i[i*29 +: 29] = slot[i];
        model_edge();
        @(posedge clock_i);
        @(negedge clock_i);
        compare_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},    32'(stall_o),           0);
        chk({tag, "_valid"},    32'(dispatchValid_o),   0);
        chk({tag, "_payload"},  32'(dispatchPayload_o), 0);
        chk({tag, "_unit"},     32'(dispatchUnit_o),    0);
        chk({tag, "_conflict"}, 32'(conflict_o),        0);
        chk({tag, "_overflow"}, 32'(overflow_o),        0);
        chk({tag, "_bad"},      32'(badUnit_o),         0);
        chk({tag, "_occ"},      32'(occupancy_o),       0);
    endtask

    initial begin
        logic [28:0] p;
        reset_i      = 1'b1;
        decEnable_i  = '0;
        decPayload_i = '0;
        fuReady_i    = '0;
        for (int i = 0; i < 4; i++) slot[i] = '0;
        model_clear();
        @(negedge clock_i);
        @(negedge clock_i);
        chk_all_zero("reset");
        reset_i = 1'b0;

        // Single FX instruction, all units ready.
        slot[0] = mk(5'd1, 5'd2, 5'd3, 9'd266, 1'b0, 1'b0, 3'd0);
        cycle(4'b0001, 5'h1F);
        chk("t1_occ_after_push", 32'(occupancy_o), 1);
        chk("t1_no_early_valid", 32'(dispatchValid_o), 0);
        slot[0] = '0;
        cycle(4'b0000, 5'h1F);
        p = dispatchPayload_o;
        chk("t1_valid", 32'(dispatchValid_o), 1);
        chk("t1_unit", 32'(dispatchUnit_o), 0);
        chk("t1_xop", 32'(p[13:5]), 266);
        chk("t1_occ_drained", 32'(occupancy_o), 0);

        // Two enables: lowest wins, conflict pulses once.
        slot[1] = mk(5'd4, 5'd5, 5'd6, 9'd40, 1'b1, 1'b0, 3'd0);
        slot[2] = mk(5'd7, 5'd8, 5'd9, 9'd10, 1'b0, 1'b1, 3'd0);
        cycle(4'b0110, 5'h00);
        chk("t2_conflict", 32'(conflict_o), 1);
        chk("t2_occ", 32'(occupancy_o), 1);
        cycle(4'b0000, 5'h00);
        chk("t2_conflict_once", 32'(conflict_o), 0);
        cycle(4'b0000, 5'h1F);
        p = dispatchPayload_o;
        chk("t2_xop", 32'(p[13:5]), 40);

        // Fill to overflow, then drain in order.
        for (int k = 0; k < 5; k++) begin
            slot[0] = mk(5'(k), 5'd0, 5'd0, 9'(100 + k), 1'b0, 1'b0, 3'd0);
            cycle(4'b0001, 5'h00);
            if (k == 1) chk("t3_stall_low_at2", 32'(stall_o), 0);
            if (k == 2) chk("t3_stall_high_at3", 32'(stall_o), 1);
        end
        chk("t3_overflow", 32'(overflow_o), 1);
        chk("t3_occ_full", 32'(occupancy_o), 4);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 5'h1F);
            p = dispatchPayload_o;
            chk("t3_drain_valid", 32'(dispatchValid_o), 1);
            chk("t3_drain_order", 32'(p[13:5]), 32'(100 + k));
            if (k == 0) chk("t3_overflow_once", 32'(overflow_o), 0);
            if (k == 0) chk("t3_stall_at3", 32'(stall_o), 1);
            if (k == 1) chk("t3_stall_drop", 32'(stall_o), 0);
        end
        cycle(4'b0000, 5'h1F);
        chk("t3_idle", 32'(dispatchValid_o), 0);

        // Blocked FP head must not be bypassed by a ready FX entry.
        slot[0] = mk(5'd1, 5'd1, 5'd1, 9'd21, 1'b0, 1'b0, 3'd1);
        cycle(4'b0001, 5'b00001);
        slot[0] = mk(5'd2, 5'd2, 5'd2, 9'd22, 1'b0, 1'b0, 3'd0);
        cycle(4'b0001, 5'b00001);
        cycle(4'b0000, 5'b00001);
        chk("t4_no_bypass", 32'(dispatchValid_o), 0);
        chk("t4_occ_blocked", 32'(occupancy_o), 2);
        cycle(4'b0000, 5'b00011);
        chk("t4_fp_first", 32'(dispatchUnit_o), 1);
        cycle(4'b0000, 5'b00011);
        chk("t4_fx_second_valid", 32'(dispatchValid_o), 1);
        chk("t4_fx_second", 32'(dispatchUnit_o), 0);

        // Bad unit code is discarded.
        slot[0] = mk(5'd3, 5'd3, 5'd3, 9'd33, 1'b0, 1'b0, 3'd6);
        cycle(4'b0001, 5'h1F);
        cycle(4'b0000, 5'h1F);
        chk("t5_bad", 32'(badUnit_o), 1);
        chk("t5_bad_novalid", 32'(dispatchValid_o), 0);
        chk("t5_bad_occ", 32'(occupancy_o), 0);
        cycle(4'b0000, 5'h1F);
        chk("t5_bad_once", 32'(badUnit_o), 0);

        // Asynchronous reset mid-operation flushes the queue.
        for (int k = 0; k < 3; k++) begin
            slot[0] = mk(5'(k), 5'd0, 5'd0, 9'(200 + k), 1'b0, 1'b0, 3'd0);
            cycle(4'b0001, 5'h00);
        end
        chk("t6_occ_before", 32'(occupancy_o), 3);
        decEnable_i = '0;
        #2 reset_i = 1'b1;
        #1 chk_all_zero("async_reset");
        model_clear();
        @(negedge clock_i);
        reset_i = 1'b0;
        cycle(4'b0000, 5'h1F);
        chk("t6_no_issue", 32'(dispatchValid_o), 0);
        cycle(4'b0000, 5'h1F);
        chk("t6_occ_after", 32'(occupancy_o), 0);

        // Randomised traffic against the queue model.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] en;
            for (int i = 0; i < 4; i++) begin
                logic [2:0] fu;
                fu = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                slot[i] = mk(5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom),
                             1'($urandom), 1'($urandom), fu);
            end
            en = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            cycle(en, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
